// File: rtl/half_adder_core.sv
// Bit-wise half adder: combinational sum/carry, a one-cycle registered copy
// with a valid strobe, and a saturating count of accepted pairs that carried.
module half_adder_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] w_sum_p0;
  logic [WIDTH-1:0] w_carry_p0;
  logic             w_any_carry_p0;

  logic [WIDTH-1:0] r_sum_p1;
  logic [WIDTH-1:0] r_carry_p1;
  logic             r_vld_p1;
  logic [CNT_W-1:0] r_cnt_p1;

  // Stage p0: combinational half adders, independent per bit
  assign w_sum_p0       = a ^ b;
  assign w_carry_p0     = a & b;
  assign w_any_carry_p0 = |w_carry_p0;

  assign sum   = w_sum_p0;
  assign carry = w_carry_p0;

  // Stage p1: captured pair, valid pulse and carry-event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p1   <= '0;
      r_carry_p1 <= '0;
      r_vld_p1   <= 1'b0;
      r_cnt_p1   <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_sum_p1   <= w_sum_p0;
        r_carry_p1 <= w_carry_p0;
        if (w_any_carry_p0) begin
          r_cnt_p1 <= sat_inc(r_cnt_p1);
        end
      end
    end
  end

  assign sum_q     = r_sum_p1;
  assign carry_q   = r_carry_p1;
  assign out_valid = r_vld_p1;
  assign carry_cnt = r_cnt_p1;

endmodule

// File: tb/tb_half_adder_core.sv
// Scoreboard bench for half_adder_core (WIDTH=8, CNT_W=8): driver pushes the
// expected registered response per cycle, a monitor pops and compares.
module tb_half_adder_core;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  a, b;
  logic [W-1:0]  sum, carry, sum_q, carry_q;
  logic          out_valid;
  logic [CW-1:0] carry_cnt;

  half_adder_core #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
    .out_valid(out_valid), .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           events = 0;
  logic [W-1:0] last_s = '0;
  logic [W-1:0] last_c = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: per-bit integer addition, carry events counted then clipped
  task automatic push_exp(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb);
    exp_t e;
    int t;
    logic [W-1:0] s, c;
    if (v) begin
      for (int i = 0; i < W; i++) begin
        t = int'(ta[i]) + int'(tb[i]);
        s[i] = (t % 2) == 1;
        c[i] = (t / 2) == 1;
      end
      if (c != 0) events++;
      last_s = s;
      last_c = c;
    end
    e.vld = v;
    e.s   = last_s;
    e.c   = last_c;
    e.cnt = CW'((events > CNT_MAX) ? CNT_MAX : events);
    q.push_back(e);
  endtask

  task automatic chk_comb();
    logic [W-1:0] es, ec;
    int t;
    for (int i = 0; i < W; i++) begin
      t = int'(a[i]) + int'(b[i]);
      es[i] = (t % 2) == 1;
      ec[i] = (t / 2) == 1;
    end
    chk("comb_carry_sum", {16'h0, carry, sum}, {16'h0, ec, es});
  endtask

  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb);
    @(negedge clk);
    #1;
    in_valid = v;
    a = ta;
    b = tb;
    push_exp(v, ta, tb);
    #1 chk_comb();
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    push_exp(1'b0, a, b);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sum_q"}, 32'(sum_q), 32'h0);
    chk({tag, "_carry_q"}, 32'(carry_q), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_carry_cnt"}, 32'(carry_cnt), 32'h0);
  endtask

  // Monitor: one expectation per cycle, compared after the capture edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        chk("sum_q", 32'(sum_q), 32'(e.s));
        chk("carry_q", 32'(carry_q), 32'(e.c));
        chk("carry_cnt", 32'(carry_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tt;
    rst_n = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("por");

    // Truth table on bit 0 while reset is held
    for (int i = 0; i < 4; i++) begin
      tt = 2'(i);
      a = {7'b0, tt[1]};
      b = {7'b0, tt[0]};
      #1 chk_comb();
      #9;
    end
    chk_reset_state("por_hold");

    release_rst();
    drive(1'b1, 8'h01, 8'h01);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h55, 8'hAA);
    drive(1'b1, 8'h0B, 8'h06);
    drive(1'b1, 8'h01, 8'h00);

    for (int i = 0; i < 1000; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    for (int i = 0; i < 280; i++)
      drive(1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 8'hF0, 8'h0F);

    // Asynchronous reset between edges with valid traffic presented
    drive(1'b1, 8'h3C, 8'h3C);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 8'hC3;
    b = 8'h81;
    #1 chk_reset_state("mid");
    chk_comb();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      a = 8'($urandom);
      b = 8'($urandom);
      #1 chk_reset_state("mid_hold");
      chk_comb();
    end
    events = 0;
    last_s = '0;
    last_c = '0;
    release_rst();
    drive(1'b1, 8'h0E, 8'h0B);
    drive(1'b1, 8'h01, 8'h02);
    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    drive(1'b0, 8'h00, 8'h00);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
